uart_cmd_decode: RTL and testbench



---
 rtl/orbtrace_cmd_pkg.sv | 29 ++
 rtl/cmd_timer.sv | 28 ++
 rtl/uart_cmd_decode.sv | 163 ++++++++++++++++
 tb/tb_uart_cmd_decode.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orbtrace_cmd_pkg.sv
// Shared constants, state encoding and helpers for the host command decoder.
package orbtrace_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam logic [7:0] ACK_BYTE       = 8'h06;
    localparam logic [7:0] NAK_BYTE       = 8'h15;

    localparam logic [7:0] CMD_SET_WIDTH  = 8'h01;
    localparam logic [7:0] CMD_SET_ENABLE = 8'h02;
    localparam logic [7:0] CMD_PING       = 8'h03;

    typedef enum logic [2:0] {
        IDLE, CMD, LEN, PAYLOAD, CHK, EXEC, RESP
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Unused payload slots are cleared at SYNC, so they drop out of the XOR.
    function automatic logic [7:0] frame_xor(
        input logic [7:0]      cmd,
        input logic [7:0]      len,
        input logic [3:0][7:0] pl
    );
        return cmd ^ len ^ pl[0] ^ pl[1] ^ pl[2] ^ pl[3];
    endfunction

endpackage

// File: rtl/cmd_timer.sv
// Inter-byte gap timer: expired pulses on the TIMEOUT_CYCLES-th idle run cycle.
module cmd_timer #(
    parameter int TIMEOUT_CYCLES = 48_000
) (
    input  logic clkOut,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clkOut) begin
        if (rst || i_clear || !i_run) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // A byte in the expiry cycle wins, so clear masks the pulse.
    assign o_expired = i_run && !i_clear && (r_count == LAST);

endmodule

// File: rtl/uart_cmd_decode.sv
// Host-to-probe command decoder: parses framed UART commands, updates
// trace configuration and returns one ACK/NAK byte per validated frame.
module uart_cmd_decode
    import orbtrace_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 48_000,
    parameter int MAX_LEN        = 4
) (
    input  logic       clkOut,
    input  logic       rst,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    output logic [2:0] width,
    output logic       traceEn,
    output logic       cmdStrobe,
    output logic       respValid,
    output logic [7:0] respByte,
    input  logic       respTaken,
    output logic [7:0] errCount
);

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_len;
    logic [3:0][7:0] r_payload;
    logic [1:0]      r_idx;
    logic            r_chkOk;

    logic            w_run;
    logic            w_expired;
    logic            w_lenOk;
    logic            w_argOk;
    logic            w_exec;
    logic [7:0]      w_arg;

    assign w_run = (r_state == CMD) || (r_state == LEN) ||
                   (r_state == PAYLOAD) || (r_state == CHK);
    assign w_arg = r_payload[0];

    cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clkOut   (clkOut),
        .rst      (rst),
        .i_clear  (received),
        .i_run    (w_run),
        .o_expired(w_expired)
    );

    always_comb begin
        w_lenOk = 1'b0;
        w_argOk = 1'b0;
        case (r_cmd)
            CMD_SET_WIDTH: begin
                w_lenOk = (r_len == 8'd1);
                w_argOk = (w_arg == 8'd1) || (w_arg == 8'd2) ||
                          (w_arg == 8'd4);
            end
            CMD_SET_ENABLE: begin
                w_lenOk = (r_len == 8'd1);
                w_argOk = 1'b1;
            end
            CMD_PING: begin
                w_lenOk = (r_len == 8'd0);
                w_argOk = 1'b1;
            end
            default: ;
        endcase
        w_exec = r_chkOk && w_lenOk && w_argOk;
    end

    always_ff @(posedge clkOut) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cmd     <= 8'd0;
            r_len     <= 8'd0;
            r_payload <= '0;
            r_idx     <= 2'd0;
            r_chkOk   <= 1'b0;
            width     <= 3'd1;
            traceEn   <= 1'b1;
            cmdStrobe <= 1'b0;
            respValid <= 1'b0;
            respByte  <= 8'h00;
            errCount  <= 8'd0;
        end else begin
            cmdStrobe <= 1'b0;
            if (r_state == RESP) begin
                if (received || recv_error) begin
                    errCount <= sat_inc(errCount);
                end
                if (respTaken) begin
                    respValid <= 1'b0;
                    r_state   <= IDLE;
                end
            end else if (recv_error) begin
                r_state  <= IDLE;
                errCount <= sat_inc(errCount);
            end else if (r_state == EXEC) begin
                respValid <= 1'b1;
                r_state   <= RESP;
                if (w_exec) begin
                    respByte  <= ACK_BYTE;
                    cmdStrobe <= 1'b1;
                    if (r_cmd == CMD_SET_WIDTH) begin
                        width <= w_arg[2:0];
                    end
                    if (r_cmd == CMD_SET_ENABLE) begin
                        traceEn <= w_arg[0];
                    end
                end else begin
                    respByte <= NAK_BYTE;
                    errCount <= sat_inc(errCount);
                end
            end else if (received) begin
                unique case (r_state)
                    IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            r_payload <= '0;
                            r_state   <= CMD;
                        end
                    end
                    CMD: begin
                        r_cmd   <= rx_byte;
                        r_state <= LEN;
                    end
                    LEN: begin
                        r_len <= rx_byte;
                        r_idx <= 2'd0;
                        if (rx_byte > 8'(MAX_LEN)) begin
                            respValid <= 1'b1;
                            respByte  <= NAK_BYTE;
                            errCount  <= sat_inc(errCount);
                            r_state   <= RESP;
                        end else if (rx_byte == 8'd0) begin
                            r_state <= CHK;
                        end else begin
                            r_state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        r_payload[r_idx] <= rx_byte;
                        r_idx            <= r_idx + 2'd1;
                        if (({6'd0, r_idx} + 8'd1) == r_len) begin
                            r_state <= CHK;
                        end
                    end
                    CHK: begin
                        r_chkOk <= (rx_byte ==
                                    frame_xor(r_cmd, r_len, r_payload));
                        r_state <= EXEC;
                    end
                    default: ;
                endcase
            end else if (w_expired) begin
                r_state  <= IDLE;
                errCount <= sat_inc(errCount);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Scenario bench for uart_cmd_decode with a response-byte scoreboard.
module tb_uart_cmd_decode;

    localparam int TMO = 64;

    logic       clkOut;
    logic       rst;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic [2:0] width;
    logic       traceEn;
    logic       cmdStrobe;
    logic       respValid;
    logic [7:0] respByte;
    logic       respTaken;
    logic [7:0] errCount;

    int         n_cmp;
    int         n_bad;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    uart_cmd_decode #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_LEN       (4)
    ) dut (
        .clkOut    (clkOut),
        .rst       (rst),
        .received  (received),
        .rx_byte   (rx_byte),
        .recv_error(recv_error),
        .width     (width),
        .traceEn   (traceEn),
        .cmdStrobe (cmdStrobe),
        .respValid (respValid),
        .respByte  (respByte),
        .respTaken (respTaken),
        .errCount  (errCount)
    );

    initial clkOut = 1'b0;
    always #5 clkOut = ~clkOut;

    // Scoreboard: each accepted response byte is checked against the queue.
    always @(negedge clkOut) begin
        logic [7:0] e;
        if (!rst && respValid === 1'b1 && respTaken === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: got %02h, none expected",
                         respByte);
            end else begin
                e = exp_q.pop_front();
                if (respByte !== e) begin
                    n_bad++;
                    $display("FAIL resp_byte: got %02h, expected %02h",
                             respByte, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clkOut); #1;
        received = 1'b1;
        rx_byte  = b;
        @(posedge clkOut); #1;
        received = 1'b0;
    endtask

    task automatic send_q();
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i]);
        tx_q.delete();
    endtask

    task automatic wait_resp(input string nm);
        int k;
        k = 0;
        @(negedge clkOut);
        while (respValid !== 1'b1 && k < 20) begin
            @(negedge clkOut);
            k++;
        end
        n_cmp++;
        if (respValid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_wait: respValid=%b, expected 1 within 20",
                     nm, respValid);
        end
    endtask

    task automatic take_resp();
        @(posedge clkOut); #1;
        respTaken = 1'b1;
        @(posedge clkOut); #1;
        respTaken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clkOut);
        #1;
        rst = 1'b0;
        @(negedge clkOut);
        n_cmp++;
        if ({width, traceEn, cmdStrobe, respValid} !== 6'b001100) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b, expected 001100",
                     {width, traceEn, cmdStrobe, respValid});
        end
        n_cmp++;
        if ({respByte, errCount} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_bytes: got %04h, expected 0000",
                     {respByte, errCount});
        end
    endtask

    task automatic test_set_width();
        exp_q.push_back(8'h06);
        tx_q = '{8'hA5, 8'h01, 8'h01, 8'h04, 8'h04};
        send_q();
        @(negedge clkOut);
        n_cmp++;
        if ({width, cmdStrobe, respValid} !== 5'b00100) begin
            n_bad++;
            $display("FAIL width_n1: got %b, expected 00100",
                     {width, cmdStrobe, respValid});
        end
        @(negedge clkOut);
        n_cmp++;
        if ({width, cmdStrobe, respValid} !== 5'b10011) begin
            n_bad++;
            $display("FAIL width_n2: got %b, expected 10011",
                     {width, cmdStrobe, respValid});
        end
        repeat (3) @(negedge clkOut);
        n_cmp++;
        if ({cmdStrobe, respValid, respByte} !== {2'b01, 8'h06}) begin
            n_bad++;
            $display("FAIL width_hold: got %b/%02h, expected 01/06",
                     {cmdStrobe, respValid}, respByte);
        end
        take_resp();
        @(negedge clkOut);
        n_cmp++;
        if (respValid !== 1'b0) begin
            n_bad++;
            $display("FAIL width_drop: respValid=%b, expected 0", respValid);
        end
    endtask

    task automatic test_enable();
        exp_q.push_back(8'h06);
        tx_q = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h03};
        send_q();
        wait_resp("enable");
        n_cmp++;
        if (traceEn !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_val: traceEn=%b, expected 0", traceEn);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'h06);
        @(posedge clkOut); #1;
        respTaken = 1'b1;
        @(posedge clkOut); #1;
        respTaken = 1'b0;
        received  = 1'b1;
        rx_byte   = 8'hA5;
        @(posedge clkOut); #1;
        received  = 1'b0;
        tx_q = '{8'h03, 8'h00, 8'h03};
        send_q();
        wait_resp("ping");
        n_cmp++;
        if ({width, traceEn, errCount} !== {3'd4, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL ping_state: got %0d/%b/%0d, expected 4/0/0",
                     width, traceEn, errCount);
        end
        take_resp();
    endtask

    task automatic test_nak();
        exp_q.push_back(8'h15);
        tx_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'hFF};
        send_q();
        wait_resp("badchk");
        n_cmp++;
        if ({width, errCount} !== {3'd4, 8'd1}) begin
            n_bad++;
            $display("FAIL badchk_state: got %0d/%0d, expected 4/1",
                     width, errCount);
        end
        take_resp();
        exp_q.push_back(8'h15);
        tx_q = '{8'hA5, 8'h01, 8'h01, 8'h03, 8'h03};
        send_q();
        wait_resp("badwidth");
        n_cmp++;
        if ({width, errCount} !== {3'd4, 8'd2}) begin
            n_bad++;
            $display("FAIL badwidth_state: got %0d/%0d, expected 4/2",
                     width, errCount);
        end
        take_resp();
    endtask

    task automatic test_len_overflow();
        exp_q.push_back(8'h15);
        tx_q = '{8'hA5, 8'h01, 8'h05};
        send_q();
        @(negedge clkOut);
        n_cmp++;
        if ({respValid, respByte, errCount} !== {1'b1, 8'h15, 8'd3}) begin
            n_bad++;
            $display("FAIL lenmax_nak: got %b/%02h/%0d, expected 1/15/3",
                     respValid, respByte, errCount);
        end
        take_resp();
        exp_q.push_back(8'h06);
        tx_q = '{8'hA5, 8'h03, 8'h00, 8'h03};
        send_q();
        wait_resp("lenmax_next");
        n_cmp++;
        if (errCount !== 8'd3) begin
            n_bad++;
            $display("FAIL lenmax_err: errCount=%0d, expected 3", errCount);
        end
        take_resp();
    endtask

    task automatic test_timeout();
        int seen;
        seen = 0;
        tx_q = '{8'hA5, 8'h01};
        send_q();
        for (int i = 0; i < TMO; i++) begin
            @(negedge clkOut);
            if (respValid !== 1'b0) seen++;
        end
        send_byte(8'h01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clkOut);
            if (respValid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL tmo_noresp: respValid high %0d cycles, expected 0",
                     seen);
        end
        n_cmp++;
        if (errCount !== 8'd4) begin
            n_bad++;
            $display("FAIL tmo_err: errCount=%0d, expected 4", errCount);
        end
        exp_q.push_back(8'h06);
        tx_q = '{8'hA5, 8'h01};
        send_q();
        for (int i = 0; i < TMO - 1; i++) @(negedge clkOut);
        tx_q = '{8'h01, 8'h02, 8'h02};
        send_q();
        wait_resp("tmo_edge");
        n_cmp++;
        if ({width, errCount} !== {3'd2, 8'd4}) begin
            n_bad++;
            $display("FAIL tmo_edge: got %0d/%0d, expected 2/4",
                     width, errCount);
        end
        take_resp();
    endtask

    task automatic test_resp_drop();
        exp_q.push_back(8'h06);
        tx_q = '{8'hA5, 8'h03, 8'h00, 8'h03};
        send_q();
        wait_resp("drop");
        send_byte(8'hA5);
        send_byte(8'h11);
        @(posedge clkOut); #1;
        recv_error = 1'b1;
        @(posedge clkOut); #1;
        received   = 1'b1;
        rx_byte    = 8'hA5;
        @(posedge clkOut); #1;
        recv_error = 1'b0;
        received   = 1'b0;
        @(negedge clkOut);
        n_cmp++;
        if ({respValid, respByte, errCount} !== {1'b1, 8'h06, 8'd8}) begin
            n_bad++;
            $display("FAIL drop_state: got %b/%02h/%0d, expected 1/06/8",
                     respValid, respByte, errCount);
        end
        take_resp();
        @(negedge clkOut);
        n_cmp++;
        if (respValid !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_taken: respValid=%b, expected 0", respValid);
        end
    endtask

    task automatic test_recv_error();
        tx_q = '{8'hA5, 8'h01};
        send_q();
        @(posedge clkOut); #1;
        received   = 1'b1;
        rx_byte    = 8'h01;
        recv_error = 1'b1;
        @(posedge clkOut); #1;
        received   = 1'b0;
        recv_error = 1'b0;
        @(negedge clkOut);
        n_cmp++;
        if ({respValid, errCount} !== {1'b0, 8'd9}) begin
            n_bad++;
            $display("FAIL rxerr_state: got %b/%0d, expected 0/9",
                     respValid, errCount);
        end
        exp_q.push_back(8'h06);
        tx_q = '{8'hA5, 8'h02, 8'h01, 8'h01, 8'h02};
        send_q();
        wait_resp("rxerr_next");
        n_cmp++;
        if ({traceEn, errCount} !== {1'b1, 8'd9}) begin
            n_bad++;
            $display("FAIL rxerr_next: got %b/%0d, expected 1/9",
                     traceEn, errCount);
        end
        take_resp();
    endtask

    task automatic test_reset_mid();
        tx_q = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h03};
        send_q();
        exp_q.push_back(8'h06);
        wait_resp("pre_rst");
        take_resp();
        tx_q = '{8'hA5, 8'h01, 8'h02, 8'h07};
        send_q();
        @(posedge clkOut); #1;
        rst = 1'b1;
        @(posedge clkOut); #1;
        rst = 1'b0;
        @(negedge clkOut);
        n_cmp++;
        if ({width, traceEn, respValid, errCount} !== {3'd1, 2'b10, 8'd0})
        begin
            n_bad++;
            $display("FAIL rst_mid: got %0d/%b/%b/%0d, expected 1/1/0/0",
                     width, traceEn, respValid, errCount);
        end
    endtask

    task automatic test_saturate();
        @(posedge clkOut); #1;
        recv_error = 1'b1;
        repeat (254) @(posedge clkOut);
        #1;
        recv_error = 1'b0;
        @(negedge clkOut);
        n_cmp++;
        if (errCount !== 8'd254) begin
            n_bad++;
            $display("FAIL sat_254: errCount=%0d, expected 254", errCount);
        end
        @(posedge clkOut); #1;
        recv_error = 1'b1;
        repeat (6) @(posedge clkOut);
        #1;
        recv_error = 1'b0;
        @(negedge clkOut);
        n_cmp++;
        if (errCount !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_255: errCount=%0d, expected 255", errCount);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        received   = 1'b0;
        rx_byte    = 8'h00;
        recv_error = 1'b0;
        respTaken  = 1'b0;

        test_reset();
        test_set_width();
        test_enable();
        test_back_to_back();
        test_nak();
        test_len_overflow();
        test_timeout();
        test_resp_drop();
        test_recv_error();
        test_reset_mid();
        test_saturate();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
